mask_builder: RTL and testbench

MASK_BUILDER -- requirements
Module: mask_builder

---
 rtl/mask_builder_pkg.sv | 19 +
 rtl/idx_onehot.sv | 27 ++
 rtl/mask_builder.sv | 118 +++++++++++
 tb/tb_mask_builder.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mask_builder_pkg.sv
// Shared constants for the mask builder slice.
//
// Holds the index/mask/count widths, the two FSM state encodings and the
// index limits used by both the one-hot converter and the mask builder.
// An index of IDX_NONE names no bit; IDX_MIN..IDX_MAX name bits 0..31.
package mask_builder_pkg;

    localparam int IDX_W  = 6;
    localparam int MASK_W = 32;
    localparam int CNT_W  = 6;

    localparam logic [0:0] COLLECT = 1'b0;
    localparam logic [0:0] EMIT    = 1'b1;

    localparam logic [IDX_W-1:0] IDX_NONE = 6'd0;
    localparam logic [IDX_W-1:0] IDX_MIN  = 6'd1;
    localparam logic [IDX_W-1:0] IDX_MAX  = 6'd32;

endpackage

// File: rtl/idx_onehot.sv
// Converts a 1-based bit index into a one-hot 32-bit vector.
//
// Ports:
//   idx       input  [5:0]   1-based index (1..32 selects bit idx-1)
//   onehot    output [31:0]  one-hot vector, all zero when idx is out of range
//   in_range  output         idx lies in 1..32
//
// Purely combinational; index 0 and indices above 32 both give a zero vector,
// the caller uses in_range plus idx itself to tell "empty" from "bad".
module idx_onehot
    import mask_builder_pkg::*;
(
    input  logic [IDX_W-1:0]  idx,
    output logic [MASK_W-1:0] onehot,
    output logic              in_range
);

    // Range test first so the shift is only used for legal indices.
    always_comb begin
        in_range = (idx >= IDX_MIN) && (idx <= IDX_MAX);
        onehot   = '0;
        if (in_range) begin
            onehot = MASK_W'(1) << (idx - IDX_MIN);
        end
    end

endmodule

// File: rtl/mask_builder.sv
// Rebuilds a 32-bit mask from a stream of 1-based bit indices.
//
// Ports:
//   clk        input         rising-edge clock
//   reset      input         synchronous active-high reset
//   in_valid   input         a beat is offered on in_idx/in_last
//   in_ready   output        block is collecting (accepts beats)
//   in_idx     input  [5:0]  1..32 sets bit idx-1, 0 is an empty beat,
//                            33..63 is flagged as an error
//   in_last    input         beat closes the current word
//   out_valid  output        an assembled word is presented
//   out_ready  input         consumer takes the word this cycle
//   out_mask   output [31:0] assembled mask
//   out_count  output [5:0]  number of distinct bits set
//   out_dup    output        a beat repeated an already-set bit
//   out_err    output        a beat carried an index of 33..63
//
// Two states: COLLECT accumulates beats, EMIT holds the finished word until
// it is taken. All outputs come straight from registers; the handshake cycle
// clears the accumulator, which costs one bubble between words.
module mask_builder
    import mask_builder_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IDX_W-1:0]  in_idx,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [MASK_W-1:0] out_mask,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_dup,
    output logic              out_err
);

    logic [0:0]        state;
    logic [MASK_W-1:0] acc_mask;
    logic [CNT_W-1:0]  acc_count;
    logic              dup_flag;
    logic              err_flag;

    logic [MASK_W-1:0] beat_onehot;
    logic              beat_in_range;
    logic              beat_accept;
    logic              beat_is_dup;
    logic              beat_is_err;

    idx_onehot u_idx_onehot (
        .idx      (in_idx),
        .onehot   (beat_onehot),
        .in_range (beat_in_range)
    );

    // Handshake flags depend on state alone, so nothing on the input side
    // reaches the outputs combinationally.
    always_comb begin
        in_ready    = (state == COLLECT);
        out_valid   = (state == EMIT);
        beat_accept = in_valid && in_ready;
        beat_is_dup = beat_in_range && ((acc_mask & beat_onehot) != '0);
        beat_is_err = !beat_in_range && (in_idx != IDX_NONE);
    end

    // FSM, accumulator, distinct-bit counter and sticky flags. A repeated
    // bit only raises the dup flag, so the count can reach 32 at most and
    // never wraps. Reset wins over any beat or handshake on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= COLLECT;
            acc_mask  <= '0;
            acc_count <= '0;
            dup_flag  <= 1'b0;
            err_flag  <= 1'b0;
        end else begin
            case (state)
                COLLECT: begin
                    if (beat_accept) begin
                        if (beat_is_dup) begin
                            dup_flag <= 1'b1;
                        end else if (beat_in_range) begin
                            acc_mask  <= acc_mask | beat_onehot;
                            acc_count <= acc_count + CNT_W'(1);
                        end
                        if (beat_is_err) begin
                            err_flag <= 1'b1;
                        end
                        if (in_last) begin
                            state <= EMIT;
                        end
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        state     <= COLLECT;
                        acc_mask  <= '0;
                        acc_count <= '0;
                        dup_flag  <= 1'b0;
                        err_flag  <= 1'b0;
                    end
                end
                default: begin
                    state <= COLLECT;
                end
            endcase
        end
    end

    // Outputs are the registers themselves.
    always_comb begin
        out_mask  = acc_mask;
        out_count = acc_count;
        out_dup   = dup_flag;
        out_err   = err_flag;
    end

endmodule

// File: tb/tb_mask_builder.sv
// Self-checking bench for mask_builder: directed words plus a back-to-back
// random stream, with a scoreboard of expected words built from the beats.
module tb_mask_builder;

    typedef struct packed {
        logic [31:0] mask;
        logic [5:0]  count;
        logic        dup;
        logic        err;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  in_idx;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_mask;
    logic [5:0]  out_count;
    logic        out_dup;
    logic        out_err;

    int checks   = 0;
    int failures = 0;
    int bubbles  = 0;
    int words    = 0;

    exp_t        sb[$];
    logic [31:0] m_mask;
    logic [5:0]  m_count;
    logic        m_dup;
    logic        m_err;

    mask_builder dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_idx    (in_idx),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_mask  (out_mask),
        .out_count (out_count),
        .out_dup   (out_dup),
        .out_err   (out_err)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic reportTimeout(input string tag);
        checks++;
        failures++;
        $display("[TB] FAIL %s observed=timeout expected=handshake", tag);
    endtask

    task automatic clearModel();
        m_mask  = '0;
        m_count = '0;
        m_dup   = 1'b0;
        m_err   = 1'b0;
    endtask

    // Pops the oldest expected word and compares it with the presented word.
    task automatic checkOutput();
        exp_t e;
        if (sb.size() == 0) begin
            reportTimeout("sb_empty");
        end else begin
            e = sb.pop_front();
            checkVal("sb_mask", out_mask, e.mask);
            checkVal("sb_count", 32'(out_count), 32'(e.count));
            checkVal("sb_dup", 32'(out_dup), 32'(e.dup));
            checkVal("sb_err", 32'(out_err), 32'(e.err));
        end
    endtask

    // Offers one beat starting at a falling edge and returns at the falling
    // edge after it is accepted. EMIT cycles seen meanwhile are counted as
    // bubbles, and taken words are checked against the scoreboard.
    task automatic applyStimulus(input logic [5:0] idx, input logic last);
        logic [31:0] bit_v;
        int          n;
        in_valid = 1'b1;
        in_idx   = idx;
        in_last  = last;
        n = 0;
        while (!in_ready && n < 100) begin
            bubbles++;
            if (out_valid && out_ready) checkOutput();
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            reportTimeout("beat_accept");
        end else begin
            if (idx >= 6'd1 && idx <= 6'd32) begin
                bit_v = 32'h1 << (idx - 6'd1);
                if ((m_mask & bit_v) != 0) m_dup = 1'b1;
                else begin
                    m_mask  = m_mask | bit_v;
                    m_count = m_count + 6'd1;
                end
            end else if (idx > 6'd32) begin
                m_err = 1'b1;
            end
            if (last) begin
                sb.push_back({m_mask, m_count, m_dup, m_err});
                clearModel();
                words++;
            end
            @(negedge clk);
        end
    endtask

    // Idles the input, waits for a presented word and takes it.
    task automatic takeWord();
        int n;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) begin
            reportTimeout("word_emit");
        end else begin
            bubbles++;
            checkOutput();
            @(negedge clk);
        end
    endtask

    task automatic checkWord(input string tag, input logic [31:0] mask, input logic [5:0] cnt,
                             input logic dup, input logic err);
        checkVal({tag, "_valid"}, 32'(out_valid), 32'd1);
        checkVal({tag, "_mask"}, out_mask, mask);
        checkVal({tag, "_count"}, 32'(out_count), 32'(cnt));
        checkVal({tag, "_dup"}, 32'(out_dup), 32'(dup));
        checkVal({tag, "_err"}, 32'(out_err), 32'(err));
    endtask

    // Directed sequence followed by a back-to-back random stream.
    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_idx    = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        clearModel();
        repeat (2) @(negedge clk);
        reset = 1'b0;

        checkVal("rst_in_ready", 32'(in_ready), 32'd1);
        checkVal("rst_out_valid", 32'(out_valid), 32'd0);
        checkVal("rst_mask", out_mask, 32'h0);
        checkVal("rst_count", 32'(out_count), 32'd0);

        applyStimulus(6'd1, 1'b0);
        applyStimulus(6'd3, 1'b0);
        applyStimulus(6'd32, 1'b1);
        checkWord("w_1_3_32", 32'h8000_0005, 6'd3, 1'b0, 1'b0);
        takeWord();

        applyStimulus(6'd5, 1'b0);
        applyStimulus(6'd5, 1'b0);
        applyStimulus(6'd0, 1'b1);
        checkWord("w_dup", 32'h0000_0010, 6'd1, 1'b1, 1'b0);
        takeWord();

        applyStimulus(6'd40, 1'b0);
        applyStimulus(6'd2, 1'b1);
        checkWord("w_err", 32'h0000_0002, 6'd1, 1'b0, 1'b1);
        takeWord();
        applyStimulus(6'd7, 1'b1);
        checkWord("w_after_err", 32'h0000_0040, 6'd1, 1'b0, 1'b0);
        takeWord();

        out_ready = 1'b0;
        for (int i = 1; i <= 32; i++) applyStimulus(6'(i), (i == 32));
        in_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            checkWord("w_full", 32'hFFFF_FFFF, 6'd32, 1'b0, 1'b0);
            checkVal("w_full_in_ready", 32'(in_ready), 32'd0);
            if (c == 3) begin
                out_ready = 1'b1;
                checkOutput();
            end
            @(negedge clk);
        end
        checkVal("w_full_collect", 32'(in_ready), 32'd1);

        applyStimulus(6'd2, 1'b0);
        reset    = 1'b1;
        in_valid = 1'b1;
        in_idx   = 6'd9;
        in_last  = 1'b1;
        @(negedge clk);
        reset    = 1'b0;
        in_valid = 1'b0;
        clearModel();
        checkVal("rst_mid_in_ready", 32'(in_ready), 32'd1);
        checkVal("rst_mid_out_valid", 32'(out_valid), 32'd0);
        applyStimulus(6'd4, 1'b1);
        checkWord("w_post_rst", 32'h0000_0008, 6'd1, 1'b0, 1'b0);
        takeWord();

        out_ready = 1'b0;
        applyStimulus(6'd3, 1'b1);
        in_valid = 1'b0;
        checkVal("emit_before_rst", 32'(out_valid), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        sb.delete();
        checkVal("rst_emit_out_valid", 32'(out_valid), 32'd0);
        checkVal("rst_emit_in_ready", 32'(in_ready), 32'd1);
        checkVal("rst_emit_mask", out_mask, 32'h0);
        out_ready = 1'b1;

        applyStimulus(6'd0, 1'b1);
        checkWord("w_empty", 32'h0, 6'd0, 1'b0, 1'b0);
        takeWord();

        bubbles = 0;
        words   = 0;
        for (int w = 0; w < 20; w++) begin
            int beats;
            beats = $urandom_range(1, 6);
            for (int b = 0; b < beats; b++) begin
                logic [5:0] idx;
                if ($urandom_range(0, 9) == 0) idx = 6'($urandom_range(33, 63));
                else idx = 6'($urandom_range(0, 32));
                applyStimulus(idx, (b == beats - 1));
            end
        end
        takeWord();
        checkVal("b2b_bubbles", 32'(bubbles), 32'(words));
        checkVal("sb_drained", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
